// File: rtl/imem_axi_pkg.sv
// Shared constants for the instruction-memory AXI4-Lite responder.
// Holds the AXI response codes and the controller state encoding.
package imem_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    RD_RESP   = 2'd2,
    WR_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_sram_1rw.sv
// Single-port word-wide synchronous RAM with per-byte write enables and one-cycle read latency.
module imem_sram_1rw #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    IDX_W       = $clog2(DEPTH_WORDS),
  parameter string INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-during-write returns the previous contents of the word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_axi4_lite_slave.sv
// AXI4-Lite responder for the instruction SRAM: fetch reads and program-load writes,
// one transaction in flight, with independently captured AW and W channels.
module imem_axi4_lite_slave
  import imem_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,

  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,

  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,

  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,

  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t state, state_next;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  ar_in_range_q;

  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;

  logic                  aw_hs, w_hs, ar_hs, write_ready, commit;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_in_range, ar_in_range;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [31:0]           ram_rdata;

  logic                  unused_bits;

  assign aw_off      = aw_addr_q - BASE_ADDR;
  assign ar_off      = S_AXI_ARADDR - BASE_ADDR;
  assign aw_in_range = (aw_off >> (IDX_W + 2)) == '0;
  assign ar_in_range = (ar_off >> (IDX_W + 2)) == '0;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_off[1:0], ar_off[1:0]};

  assign aw_hs = S_AXI_AWVALID && !aw_held;
  assign w_hs  = S_AXI_WVALID && !w_held;

  // A write that completes this cycle also blocks AR, so a same-cycle read never overtakes it.
  assign write_ready = (aw_held || aw_hs) && (w_held || w_hs);
  assign commit      = (state == IDLE) && aw_held && w_held && !rst;
  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_AWREADY = !aw_held;
  assign S_AXI_WREADY  = !w_held;
  assign S_AXI_ARREADY = (state == IDLE) && !write_ready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  // The RAM is addressed straight from ARADDR so read data is ready in RD_ACCESS.
  assign ram_en   = commit || ar_hs;
  assign ram_we   = (commit && aw_in_range) ? w_strb_q : 4'b0000;
  assign ram_addr = commit ? aw_off[IDX_W+1:2] : ar_off[IDX_W+1:2];

  imem_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .INIT_FILE   (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (w_data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (aw_held && w_held) begin
          state_next = WR_RESP;
        end else if (ar_hs) begin
          state_next = RD_ACCESS;
        end
      end
      RD_ACCESS: state_next = RD_RESP;
      RD_RESP:   if (S_AXI_RREADY) state_next = IDLE;
      WR_RESP:   if (S_AXI_BREADY) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // AW and W are captured independently and stay held until the B handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (state == WR_RESP && S_AXI_BREADY) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_held <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_addr_q <= S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
    if (ar_hs) begin
      ar_in_range_q <= ar_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (state == WR_RESP && S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Out-of-range reads return zero data so the RAM alias never leaks onto the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (state == RD_ACCESS) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_in_range_q ? ram_rdata : 32'h0;
      rresp_q  <= ar_in_range_q ? RESP_OKAY : RESP_SLVERR;
    end else if (state == RD_RESP && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_axi4_lite_slave.sv
// Directed self-checking bench for imem_axi4_lite_slave with a 256-word memory at base 0.
module tb_imem_axi4_lite_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
  logic [3:0]  w_strb = '0;
  logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
  logic        b_ready = 1'b0, r_ready = 1'b0;

  logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;

  int checks = 0;
  int errors = 0;

  logic [1:0]  resp;
  logic [31:0] data;
  logic        lat_ok;

  always #5 clk = ~clk;

  imem_axi4_lite_slave #(
    .ADDR_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWADDR  (aw_addr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (aw_valid),
    .S_AXI_AWREADY (aw_ready),
    .S_AXI_WDATA   (w_data),
    .S_AXI_WSTRB   (w_strb),
    .S_AXI_WVALID  (w_valid),
    .S_AXI_WREADY  (w_ready),
    .S_AXI_BRESP   (b_resp),
    .S_AXI_BVALID  (b_valid),
    .S_AXI_BREADY  (b_ready),
    .S_AXI_ARADDR  (ar_addr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (ar_valid),
    .S_AXI_ARREADY (ar_ready),
    .S_AXI_RDATA   (r_data),
    .S_AXI_RRESP   (r_resp),
    .S_AXI_RVALID  (r_valid),
    .S_AXI_RREADY  (r_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Full write; lat_ok means BVALID low at T+1, high at T+2, low after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                           output logic [1:0] bresp, output logic ok);
    logic b1, b2, b3;
    aw_addr = addr; aw_valid = 1'b1;
    w_data = wd; w_strb = strb; w_valid = 1'b1;
    tick; aw_valid = 1'b0; w_valid = 1'b0; settle; b1 = b_valid;
    tick; settle; b2 = b_valid; bresp = b_resp; b_ready = 1'b1;
    tick; b_ready = 1'b0; settle; b3 = b_valid;
    ok = !b1 && b2 && !b3;
  endtask

  // Full read; ok means RVALID low at T+1, high at T+2, low after the R handshake.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] rd, output logic [1:0] rr,
                          output logic ok);
    logic r1, r2, r3;
    ar_addr = addr; ar_valid = 1'b1;
    tick; ar_valid = 1'b0; settle; r1 = r_valid;
    tick; settle; r2 = r_valid; rd = r_data; rr = r_resp; r_ready = 1'b1;
    tick; r_ready = 1'b0; settle; r3 = r_valid;
    ok = !r1 && r2 && !r3;
  endtask

  initial begin
    $display("[TB] start");

    // Reset held for two cycles
    tick; tick;
    rst = 1'b0;
    settle;
    check("rst_bvalid",  b_valid,  32'd0);
    check("rst_rvalid",  r_valid,  32'd0);
    check("rst_rdata",   r_data,   32'd0);
    check("rst_awready", aw_ready, 32'd1);
    check("rst_wready",  w_ready,  32'd1);
    check("rst_arready", ar_ready, 32'd1);

    // Full-word write then read back
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, resp, lat_ok);
    check("wr10_bresp", resp, 32'd0);
    check("wr10_lat", lat_ok, 32'd1);
    axi_read(32'h10, data, resp, lat_ok);
    check("rd10_data", data, 32'hDEAD_BEEF);
    check("rd10_rresp", resp, 32'd0);
    check("rd10_lat", lat_ok, 32'd1);

    // Partial-strobe write merges low half only
    axi_write(32'h10, 32'h1234_5678, 4'b0011, resp, lat_ok);
    check("wr10p_bresp", resp, 32'd0);
    axi_read(32'h10, data, resp, lat_ok);
    check("rd10p_data", data, 32'hDEAD_5678);

    // W three cycles ahead of AW, then BREADY held low five cycles
    w_data = 32'hCAFE_F00D; w_strb = 4'hF; w_valid = 1'b1;
    tick; w_valid = 1'b0; settle;
    check("t4_wready_held1", w_ready, 32'd0);
    check("t4_bvalid_early1", b_valid, 32'd0);
    tick; settle;
    check("t4_wready_held2", w_ready, 32'd0);
    tick; aw_addr = 32'h40; aw_valid = 1'b1; settle;
    check("t4_awready", aw_ready, 32'd1);
    check("t4_bvalid_early2", b_valid, 32'd0);
    tick; aw_valid = 1'b0; settle;
    check("t4_bvalid_t1", b_valid, 32'd0);
    check("t4_awready_held", aw_ready, 32'd0);
    tick; settle;
    check("t4_bvalid_t2", b_valid, 32'd1);
    check("t4_bresp", b_resp, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick; settle;
      check("t4_bvalid_hold", b_valid, 32'd1);
      check("t4_bresp_hold", b_resp, 32'd0);
      check("t4_awready_blk", aw_ready, 32'd0);
      check("t4_wready_blk", w_ready, 32'd0);
    end
    b_ready = 1'b1;
    tick; b_ready = 1'b0; settle;
    check("t4_bvalid_done", b_valid, 32'd0);
    check("t4_awready_back", aw_ready, 32'd1);
    check("t4_wready_back", w_ready, 32'd1);
    axi_read(32'h40, data, resp, lat_ok);
    check("t4_rd40_data", data, 32'hCAFE_F00D);

    // Boundary: last in-range word and first out-of-range address
    axi_write(32'h0, 32'h3333_4444, 4'hF, resp, lat_ok);
    axi_write(32'h3FC, 32'h1111_2222, 4'hF, resp, lat_ok);
    check("t5_wr3fc_bresp", resp, 32'd0);
    axi_write(32'h400, 32'hFFFF_FFFF, 4'hF, resp, lat_ok);
    check("t5_wr400_bresp", resp, 32'd2);
    check("t5_wr400_lat", lat_ok, 32'd1);
    axi_read(32'h400, data, resp, lat_ok);
    check("t5_rd400_rresp", resp, 32'd2);
    check("t5_rd400_data", data, 32'd0);
    axi_read(32'h3FC, data, resp, lat_ok);
    check("t5_rd3fc_data", data, 32'h1111_2222);
    check("t5_rd3fc_rresp", resp, 32'd0);
    axi_read(32'h0, data, resp, lat_ok);
    check("t5_rd0_alias", data, 32'h3333_4444);

    // Zero strobe leaves memory alone but answers OKAY
    axi_write(32'h0, 32'h9999_9999, 4'b0000, resp, lat_ok);
    check("t5_strb0_bresp", resp, 32'd0);
    axi_read(32'h0, data, resp, lat_ok);
    check("t5_strb0_data", data, 32'h3333_4444);

    // AR arrives in the same cycle W completes the write: write wins
    aw_addr = 32'h20; aw_valid = 1'b1;
    tick; aw_valid = 1'b0;
    w_data = 32'hA5A5_A5A5; w_strb = 4'hF; w_valid = 1'b1;
    ar_addr = 32'h20; ar_valid = 1'b1;
    settle;
    check("t6_arready_same", ar_ready, 32'd0);
    check("t6_wready_same", w_ready, 32'd1);
    tick; w_valid = 1'b0; settle;
    check("t6_arready_commit", ar_ready, 32'd0);
    tick; settle;
    check("t6_bvalid", b_valid, 32'd1);
    check("t6_arready_wresp", ar_ready, 32'd0);
    b_ready = 1'b1;
    tick; b_ready = 1'b0; settle;
    check("t6_bvalid_done", b_valid, 32'd0);
    check("t6_arready_idle", ar_ready, 32'd1);
    tick; ar_valid = 1'b0; settle;
    check("t6_rvalid_t1", r_valid, 32'd0);
    tick; settle;
    check("t6_rvalid_t2", r_valid, 32'd1);
    check("t6_rdata", r_data, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) begin
      tick; settle;
      check("t6_rvalid_hold", r_valid, 32'd1);
      check("t6_rdata_hold", r_data, 32'hA5A5_A5A5);
      check("t6_rresp_hold", r_resp, 32'd0);
    end
    r_ready = 1'b1;
    tick; r_ready = 1'b0; settle;
    check("t6_rvalid_done", r_valid, 32'd0);

    // Reset in the middle of a read drops it
    ar_addr = 32'h10; ar_valid = 1'b1;
    tick; ar_valid = 1'b0; rst = 1'b1;
    tick; rst = 1'b0; settle;
    check("rst_mid_rvalid", r_valid, 32'd0);
    tick; settle;
    check("rst_mid_rvalid2", r_valid, 32'd0);
    check("rst_mid_arready", ar_ready, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
